seq_hit_logger: RTL

Downstream consumer of the 1011 non-overlapping sequence detector (`statemachine`). It turns each assertion of the detector's `y` output into one counted, timestamped event. Events are buffered in a small FIFO and drained through a valid/ready port, so a slower controller or bench monitor can read detection times without missing hits. It sits on the same clock as the detector and takes `y` directly.

---
 rtl/seqdet_pkg.sv | 20 ++
 rtl/seq_hit_logger_fifo.sv | 71 +++++++
 rtl/seq_hit_logger.sv | 82 ++++++++
 3 files changed

// File: rtl/seqdet_pkg.sv
// Shared definitions for the 1011 detector and its hit logger.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seqdet_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int CNT_W_DEF = 8;
    localparam int DEPTH_DEF = 4;

    typedef logic [TS_W_DEF-1:0] ts_t;

    // Detector progress through the 1011 pattern, as probed on outstate.
    typedef enum logic [1:0] {
        DET_IDLE   = 2'b00,
        DET_GOT1   = 2'b01,
        DET_GOT10  = 2'b10,
        DET_GOT101 = 2'b11
    } det_state_t;

endpackage

// File: rtl/seq_hit_logger_fifo.sv
// Synchronous first-word-fall-through FIFO for hit timestamps.
// Latency: push visible at head one cycle later; pop advances head next cycle.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module hit_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign valid   = (level_q != '0);
    assign full    = (level_q == (AW+1)'(DEPTH));
    assign level   = level_q;
    // Pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign do_pop  = pop & valid;
    assign do_push = push & (~full | do_pop);
    // Head is forced to zero when empty so reset and clear show a clean bus.
    assign dout    = valid ? mem_q[rd_ptr_q] : '0;

    // Pointer and level next-state; clear overrides push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are only observed through valid entries.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/seq_hit_logger.sv
// Timestamps each rising edge of the detector output and queues it for readout.
// Latency: hit visible on ts_valid/hit_count one cycle after y_in rises.
// Backpressure: ts_valid/ts_ready; hits arriving while full are dropped and flagged.
module seq_hit_logger
    import seqdet_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     y_in,
    output logic                     ts_valid,
    output logic [TS_W-1:0]          ts_data,
    input  logic                     ts_ready,
    output logic [CNT_W-1:0]         hit_count,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             y_q;
    logic             hit, pop, full;

    // A level held high counts once: only the 0->1 transition is a hit.
    assign hit = y_in & ~y_q;
    assign pop = ts_valid & ts_ready;

    hit_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (hit & ~clr),
        .pop   (ts_ready),
        .din   (ts_q),
        .dout  (ts_data),
        .valid (ts_valid),
        .level (fifo_level),
        .full  (full)
    );

    // Timestamp, saturating counter and sticky drop flag next-state.
    always_comb begin
        ts_d  = ts_q + TS_W'(1);
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            ts_d  = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (hit) begin
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            if (full && !pop) ovf_d = 1'b1;
        end
    end

    // State registers; y_q keeps tracking y_in through clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            y_q   <= 1'b0;
        end else begin
            ts_q  <= ts_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            y_q   <= y_in;
        end
    end

    assign hit_count = cnt_q;
    assign overflow  = ovf_q;

endmodule
